// File: rtl/ysyx_24100029_stream_demux1to4.sv
// Registered 1-to-4 valid/ready dispatcher: one upstream stream steered to one of four
// one-entry output slots, with synchronous flush and an illegal-select error pulse.
module ysyx_24100029_stream_demux1to4 #(
   parameter int unsigned  DATA_WIDTH = 32,
   parameter bit           Is_One_Hot = 1'b1,
   localparam int unsigned SEL_WIDTH  = Is_One_Hot ? 4 : 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [SEL_WIDTH-1:0]  in_sel,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic [DATA_WIDTH-1:0] out_data0,
   output logic [DATA_WIDTH-1:0] out_data1,
   output logic [DATA_WIDTH-1:0] out_data2,
   output logic [DATA_WIDTH-1:0] out_data3,
   output logic                  sel_err
);

   logic [3:0]            dec_oh;
   logic                  sel_legal;
   logic [3:0]            slot_accept;
   logic                  xfer;
   logic [3:0]            load;
   logic [3:0]            valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q [4];
   logic [DATA_WIDTH-1:0] data_d [4];
   logic                  err_q, err_d;

   if (Is_One_Hot) begin : g_dec_oh
      always_comb begin
         dec_oh    = in_sel;
         sel_legal = $onehot(in_sel);
      end
   end else begin : g_dec_bin
      always_comb begin
         dec_oh    = 4'b0001 << in_sel;
         sel_legal = 1'b1;
      end
   end

   // A slot accepts when empty or draining in the same cycle.
   assign slot_accept = ~valid_q | out_ready;

   // Illegal selects are always taken so they can be dropped and flagged.
   assign in_ready = ~flush & (~sel_legal | (|(dec_oh & slot_accept)));
   assign xfer     = in_valid & in_ready;
   assign load     = {4{xfer & sel_legal}} & dec_oh;

   always_comb begin
      valid_d = '0;
      err_d   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         data_d[k] = load[k] ? in_data : data_q[k];
      end
      if (!flush) begin
         valid_d = load | (valid_q & ~out_ready);
         err_d   = xfer & ~sel_legal;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         err_q   <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign out_valid = valid_q;
   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign out_data3 = data_q[3];
   assign sel_err   = err_q;

endmodule
